// File: rtl/tbm_pkg.sv
// Shared defaults and FSM state encoding for the tbm port arbiter.
package tbm_pkg;

  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefAddrW  = 32;
  localparam int unsigned DefDataW  = 256;

  typedef logic [1:0] tbm_state_t;

  localparam tbm_state_t StIdle = 2'd0;
  localparam tbm_state_t StCmd  = 2'd1;
  localparam tbm_state_t StTurn = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first eligible requester at or after the pointer, wrapping around.
module rr_arbiter
  import tbm_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(pointer) + k) % NUM_REQ);
      if (!valid && eligible[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tbm_port_arbiter.sv
// Shares one tbm memory port between NUM_REQ requesters with round-robin arbitration
// and a one-cycle bus turnaround before a write that follows a read.
module tbm_port_arbiter
  import tbm_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_cs,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_oe,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  tbm_state_t          state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     turn_idx_q;
  logic [NUM_REQ-1:0]  rd_q;

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  win_oh;
  logic                win_valid;
  logic [PtrW-1:0]     win_idx;
  logic                issue;
  logic                turn_load;
  logic [PtrW-1:0]     issue_idx;
  logic [NUM_REQ-1:0]  issue_oh;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Masking with gnt keeps a requester that still holds req in its grant cycle from reissuing.
  assign eligible = req & ~gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_rr_arbiter (
    .eligible (eligible),
    .pointer  (ptr_q),
    .winner   (win_oh),
    .valid    (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_idx = PtrW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    turn_load = 1'b0;
    issue_idx = win_idx;
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StCmd;
          issue   = 1'b1;
        end
      end
      StCmd: begin
        if (!win_valid) begin
          state_d = StIdle;
        end else if (req_we[win_idx] && !mem_we) begin
          // Memory drives the bus next cycle for the read on the port now.
          state_d   = StTurn;
          turn_load = 1'b1;
        end else begin
          issue = 1'b1;
        end
      end
      StTurn: begin
        state_d   = StCmd;
        issue     = 1'b1;
        issue_idx = turn_idx_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    issue_oh  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (issue_idx == PtrW'(i)) begin
        sel_we      = req_we[i];
        sel_addr    = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata   = req_wdata[i*DATA_W +: DATA_W];
        issue_oh[i] = 1'b1;
      end
    end
  end

  assign ptr_d = (issue_idx == PtrW'(NUM_REQ - 1)) ? '0 : issue_idx + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      turn_idx_q <= '0;
      rd_q       <= '0;
      gnt        <= '0;
      rvalid     <= '0;
      rdata      <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_oe     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= '0;
      mem_cs  <= 1'b0;
      mem_we  <= 1'b0;
      mem_oe  <= 1'b0;
      if (turn_load) turn_idx_q <= win_idx;
      if (issue) begin
        gnt       <= issue_oh;
        mem_cs    <= 1'b1;
        mem_we    <= sel_we;
        mem_oe    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        ptr_q     <= ptr_d;
      end
      // Read data returns on the bus the cycle after the command and is presented one later.
      rd_q   <= gnt & {NUM_REQ{mem_cs & ~mem_we}};
      rvalid <= rd_q;
      if (|rd_q) rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_tbm_port_arbiter.sv
// Self-checking bench for tbm_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_tbm_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 256;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req     = '0;
  logic [NR-1:0]     req_we  = '0;
  logic [NR*AW-1:0]  req_addr  = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     rvalid;
  logic [DW-1:0]     rdata;
  logic              mem_cs;
  logic              mem_we;
  logic              mem_oe;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  tbm_port_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_oe    (mem_oe),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory environment: returns read data on the bus in the cycle after a read command.
  logic [DW-1:0] env_mem [logic [AW-1:0]];
  logic          env_last_rd   = 1'b0;
  logic [AW-1:0] env_last_addr = '0;

  always @(posedge clock) begin
    #1;
    if (env_last_rd) mem_rdata = env_mem.exists(env_last_addr) ? env_mem[env_last_addr] : '0;
    else             mem_rdata = {8{$urandom()}};
    if (mem_cs && mem_we) env_mem[mem_addr] = mem_wdata;
    env_last_rd   = mem_cs && !mem_we;
    env_last_addr = mem_addr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i]                = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = '0;
    tick();
    tick();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (rvalid !== '0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++;
    if ({mem_cs, mem_we, mem_oe} !== 3'b000) begin
      errors++; $display("FAIL reset_ctl: got %b want 000", {mem_cs, mem_we, mem_oe});
    end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
  endtask

  // Reset still asserted on entry: request and release together, grant must follow the first edge.
  task automatic test_write_read();
    set_req(0, 1'b1, 32'h0, 256'hFFFF);
    reset_n = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wr_gnt: got %b want 0001", gnt); end
    checks++;
    if ({mem_cs, mem_we, mem_oe} !== 3'b111) begin
      errors++; $display("FAIL wr_ctl: got %b want 111", {mem_cs, mem_we, mem_oe});
    end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wr_addr: got %h want 0", mem_addr); end
    checks++;
    if (mem_wdata !== 256'hFFFF) begin errors++; $display("FAIL wr_wdata: got %h want ffff", mem_wdata); end
    req[0] = 1'b0;
    set_req(1, 1'b0, 32'h0, '0);
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rd_gnt: got %b want 0010", gnt); end
    checks++;
    if ({mem_cs, mem_we, mem_oe} !== 3'b100) begin
      errors++; $display("FAIL rd_ctl: got %b want 100", {mem_cs, mem_we, mem_oe});
    end
    req[1] = 1'b0;
    tick();
    checks++;
    if (gnt !== '0 || mem_cs !== 1'b0 || rvalid !== '0) begin
      errors++; $display("FAIL rd_gap: got gnt=%b cs=%b rvalid=%b want 0/0/0", gnt, mem_cs, rvalid);
    end
    tick();
    checks++; if (rvalid !== 4'b0010) begin errors++; $display("FAIL rd_rvalid: got %b want 0010", rvalid); end
    checks++; if (rdata !== 256'hFFFF) begin errors++; $display("FAIL rd_rdata: got %h want ffff", rdata); end
    tick();
    checks++; if (rvalid !== '0) begin errors++; $display("FAIL rd_rvalid_end: got %b want 0", rvalid); end
  endtask

  task automatic test_all_read();
    logic [3:0] eg, ev;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i), '0);
    for (int t = 1; t <= 7; t++) begin
      tick();
      eg = (t <= 4) ? 4'(1 << (t - 1)) : 4'd0;
      ev = (t >= 3 && t <= 6) ? 4'(1 << (t - 3)) : 4'd0;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL all_gnt t%0d: got %b want %b", t, gnt, eg); end
      checks++;
      if (rvalid !== ev) begin errors++; $display("FAIL all_rvalid t%0d: got %b want %b", t, rvalid, ev); end
      if (t >= 2 && t <= 5) req[t-2] = 1'b0;
    end
  endtask

  task automatic test_turnaround();
    do_reset();
    set_req(2, 1'b0, 32'h5, '0);
    set_req(3, 1'b1, 32'h6, 256'h1234_5678);
    tick();
    checks++;
    if (gnt !== 4'b0100 || {mem_cs, mem_we, mem_oe} !== 3'b100) begin
      errors++; $display("FAIL ta_read: got gnt=%b ctl=%b want 0100/100", gnt, {mem_cs, mem_we, mem_oe});
    end
    req[2] = 1'b0;
    tick();
    checks++;
    if (gnt !== '0 || mem_cs !== 1'b0 || mem_oe !== 1'b0) begin
      errors++; $display("FAIL ta_turn: got gnt=%b cs=%b oe=%b want 0/0/0", gnt, mem_cs, mem_oe);
    end
    tick();
    checks++;
    if (gnt !== 4'b1000 || {mem_cs, mem_we, mem_oe} !== 3'b111 || mem_addr !== 32'h6) begin
      errors++;
      $display("FAIL ta_write: got gnt=%b ctl=%b addr=%h want 1000/111/6", gnt,
               {mem_cs, mem_we, mem_oe}, mem_addr);
    end
    checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL ta_rvalid: got %b want 0100", rvalid); end
    req[3] = 1'b0;
    tick();
    checks++;
    if (gnt !== '0 || mem_cs !== 1'b0) begin
      errors++; $display("FAIL ta_idle: got gnt=%b cs=%b want 0/0", gnt, mem_cs);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    set_req(1, 1'b0, 32'h0, '0);
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mr_gnt: got %b want 0010", gnt); end
    req[1] = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || rvalid !== '0 || rdata !== '0 || {mem_cs, mem_we, mem_oe} !== 3'b000 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL mr_reset: got gnt=%b rvalid=%b ctl=%b addr=%h want all zero", gnt, rvalid,
               {mem_cs, mem_we, mem_oe}, mem_addr);
    end
    #2;
    reset_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++;
      if (rvalid !== '0 || gnt !== '0) begin
        errors++; $display("FAIL mr_after t%0d: got rvalid=%b gnt=%b want 0/0", t, rvalid, gnt);
      end
    end
  endtask

  // Reference model: predicts the port one cycle ahead from the arbitration rules.
  logic [NR-1:0] exp_gnt, exp_rvalid, m_rd_last;
  logic          exp_cs, exp_we, exp_oe;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rdata;
  int            m_ptr, m_turn_w;
  bit            m_turn;
  logic [DW-1:0] m_rq[$];
  logic [DW-1:0] model_mem [logic [AW-1:0]];

  task automatic model_predict();
    int            w;
    bit            cur_read;
    logic [NR-1:0] rd_cur;
    logic [AW-1:0] a;
    cur_read = exp_cs && !exp_we;
    rd_cur   = cur_read ? exp_gnt : '0;
    exp_rvalid = m_rd_last;
    if (m_rd_last != 0) exp_rdata = m_rq.pop_front();
    m_rd_last = rd_cur;
    w = -1;
    if (m_turn) begin
      w      = m_turn_w;
      m_turn = 1'b0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (w < 0 && req[i] && !exp_gnt[i]) w = i;
      end
      if (w >= 0 && req_we[w] && cur_read) begin
        m_turn   = 1'b1;
        m_turn_w = w;
        w        = -1;
      end
    end
    if (w >= 0) begin
      a         = req_addr[w*AW +: AW];
      exp_gnt   = 4'(1 << w);
      exp_cs    = 1'b1;
      exp_we    = req_we[w];
      exp_oe    = req_we[w];
      exp_addr  = a;
      exp_wdata = req_wdata[w*DW +: DW];
      m_ptr     = (w + 1) % NR;
      if (req_we[w]) model_mem[a] = req_wdata[w*DW +: DW];
      else m_rq.push_back(model_mem.exists(a) ? model_mem[a] : '0);
    end else begin
      exp_gnt = '0;
      exp_cs  = 1'b0;
      exp_we  = 1'b0;
      exp_oe  = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] prev_gnt, cur;
    do_reset();
    exp_gnt = '0; exp_rvalid = '0; m_rd_last = '0;
    exp_cs = 1'b0; exp_we = 1'b0; exp_oe = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    m_ptr = 0; m_turn = 1'b0; m_turn_w = 0;
    m_rq.delete();
    prev_gnt = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ((req[i] && prev_gnt[i] && $urandom_range(1, 0) == 1) ||
            (!req[i] && $urandom_range(9, 0) < 4)) begin
          set_req(i, 1'($urandom_range(1, 0)), 32'h100 + 32'($urandom_range(7, 0)),
                  {8{$urandom()}});
        end else if (req[i] && prev_gnt[i]) begin
          req[i] = 1'b0;
        end
      end
      cur = exp_gnt;
      model_predict();
      prev_gnt = cur;
      tick();
      checks++;
      if (gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, exp_gnt); end
      checks++;
      if ({mem_cs, mem_we, mem_oe} !== {exp_cs, exp_we, exp_oe}) begin
        errors++;
        $display("FAIL rnd_ctl c%0d: got %b want %b", c, {mem_cs, mem_we, mem_oe},
                 {exp_cs, exp_we, exp_oe});
      end
      checks++;
      if (mem_addr !== exp_addr) begin
        errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, mem_addr, exp_addr);
      end
      checks++;
      if (mem_wdata !== exp_wdata) begin
        errors++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mem_wdata, exp_wdata);
      end
      checks++;
      if (rvalid !== exp_rvalid) begin
        errors++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, rvalid, exp_rvalid);
      end
      checks++;
      if (rdata !== exp_rdata) begin
        errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata, exp_rdata);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_all_read();
    test_turnaround();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
